// File: rtl/keypad_operand_ctrl.sv
// Keypad operand sequencer: builds two BCD operands from key strobes and
// hands the pair downstream over a valid/ready handshake.
module keypad_operand_ctrl #(
    parameter int DIGITS = 3,
    parameter int W      = 4 * DIGITS,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          ops_ready,
    output logic [W-1:0]  op_a,
    output logic [W-1:0]  op_b,
    output logic          ops_valid,
    output logic [W-1:0]  entry_val,
    output logic [CW-1:0] entry_cnt,
    output logic [1:0]    phase,
    output logic          key_rej
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [3:0]    KEY_ENTER = 4'hA;
    localparam logic [3:0]    KEY_BACK  = 4'hB;
    localparam logic [3:0]    KEY_CLEAR = 4'hC;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIGITS);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_base;
    logic          xfer;

    function automatic logic [W-1:0] push_digit(input logic [W-1:0] op, input logic [3:0] d);
        return {op[W-5:0], d};
    endfunction

    function automatic logic [W-1:0] drop_digit(input logic [W-1:0] op);
        return {4'h0, op[W-1:4]};
    endfunction

    // After a transfer op_a still shows the old value with cnt == 0; the
    // first new digit must start from zero instead of shifting it in.
    assign a_base    = (cnt == '0) ? '0 : op_a;
    assign xfer      = ops_valid && ops_ready;
    assign phase     = state;
    assign entry_cnt = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ENTRY_A;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            ops_valid <= 1'b0;
            entry_val <= '0;
            key_rej   <= 1'b0;
        end else begin
            key_rej <= 1'b0;
            if (xfer) begin
                // Handshake wins over any key on the same edge, including clear
                state     <= ENTRY_A;
                cnt       <= '0;
                ops_valid <= 1'b0;
                entry_val <= op_a;
                key_rej   <= key_valid;
            end else if (key_valid) begin
                if (key_code == KEY_CLEAR) begin
                    state     <= ENTRY_A;
                    cnt       <= '0;
                    op_a      <= '0;
                    op_b      <= '0;
                    ops_valid <= 1'b0;
                    entry_val <= '0;
                end else if (state == HOLD || key_code > KEY_CLEAR) begin
                    key_rej <= 1'b1;
                end else if (key_code <= 4'd9) begin
                    if (cnt == CNT_MAX) begin
                        key_rej <= 1'b1;
                    end else if (state == ENTRY_A) begin
                        op_a      <= push_digit(a_base, key_code);
                        entry_val <= push_digit(a_base, key_code);
                        if (cnt == '0)
                            op_b <= '0;
                        cnt <= cnt + 1'b1;
                    end else begin
                        op_b      <= push_digit(op_b, key_code);
                        entry_val <= push_digit(op_b, key_code);
                        cnt       <= cnt + 1'b1;
                    end
                end else if (key_code == KEY_BACK) begin
                    if (cnt == '0) begin
                        key_rej <= 1'b1;
                    end else if (state == ENTRY_A) begin
                        op_a      <= drop_digit(op_a);
                        entry_val <= drop_digit(op_a);
                        cnt       <= cnt - 1'b1;
                    end else begin
                        op_b      <= drop_digit(op_b);
                        entry_val <= drop_digit(op_b);
                        cnt       <= cnt - 1'b1;
                    end
                end else if (key_code == KEY_ENTER) begin
                    if (cnt == '0) begin
                        key_rej <= 1'b1;
                    end else if (state == ENTRY_A) begin
                        state     <= ENTRY_B;
                        cnt       <= '0;
                        op_b      <= '0;
                        entry_val <= '0;
                    end else begin
                        state     <= HOLD;
                        ops_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
